// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit control slice.
// Holds the frame-sequencing FSM states and the default payload width.
package uart_ctrl_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        GAP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the shared uart_tx arbiter.
// Master = client/test side driving requests; slave = the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = uart_ctrl_pkg::UART_DATA_W
);
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        ack;
    logic                   tx_start;
    logic [DATA_W-1:0]      tx_data;
    logic                   busy;
    logic                   frame_done;

    modport master (
        output req, req_data,
        input  ack, tx_start, tx_data, busy, frame_done
    );

    modport slave (
        input  req, req_data,
        output ack, tx_start, tx_data, busy, frame_done
    );
endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational requester arbiter: one-hot grant plus encoded index when en is high.
// Round-robin from ptr+1 by default; ARB_FIXED_PRIO_EN selects lowest-index-wins.
module uart_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] index
);

`ifdef ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Scanning downward lets the lowest asserted index overwrite any higher one.
    always_comb begin
        grant = '0;
        index = '0;
        if (en) begin
            for (int unsigned i = NREQ; i > 0; i--) begin
                if (req[i-1]) begin
                    grant        = '0;
                    grant[i-1]   = 1'b1;
                    index        = IDX_W'(i - 1);
                end
            end
        end
    end
`else
    logic        found;
    int unsigned cand;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        if (en) begin
            for (int unsigned i = 1; i <= NREQ; i++) begin
                cand = (32'(ptr) + i) % NREQ;
                if (!found && req[cand]) begin
                    found       = 1'b1;
                    grant[cand] = 1'b1;
                    index       = IDX_W'(cand);
                end
            end
        end
    end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NREQ requesters: grant, start pulse, timed frame wait, gap.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int DATA_W       = UART_DATA_W,
    parameter int START_HOLD   = 10,
    parameter int FRAME_CYCLES = 120,
    parameter int GAP_CYCLES   = 2
) (
    input  logic            clock,
    input  logic            reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(FRAME_CYCLES + 1);
    // The gap reuses the frame counter, so GAP_CYCLES must not exceed FRAME_CYCLES.
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(START_HOLD);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    uart_state_e       state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [NREQ-1:0]   grant, ack_n;
    logic [IDX_W-1:0]  gidx;
    logic              arb_en;
    logic              tx_start_n, busy_n, frame_done_n;
    logic [DATA_W-1:0] tx_data_n;

`ifdef ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]  ptr;
    assign ptr = '0;
`else
    logic [IDX_W-1:0]  ptr, ptr_n;
`endif

    assign arb_en = (state == IDLE);

    uart_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (bus.req),
        .ptr   (ptr),
        .en    (arb_en),
        .grant (grant),
        .index (gidx)
    );

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        ack_n      = '0;
        tx_start_n = 1'b0;
        tx_data_n  = bus.tx_data;
`ifndef ARB_FIXED_PRIO_EN
        ptr_n      = ptr;
`endif
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_n    = LOAD;
                    ack_n      = grant;
                    tx_data_n  = bus.req_data[gidx*DATA_W +: DATA_W];
                    tx_start_n = 1'b1;
                    cnt_n      = CNT_ONE;
`ifndef ARB_FIXED_PRIO_EN
                    ptr_n      = gidx;
`endif
                end
            end
            LOAD: begin
                cnt_n = cnt + CNT_ONE;
                if (cnt == HOLD_LAST) begin
                    state_n = WAIT;
                end else begin
                    tx_start_n = 1'b1;
                end
            end
            WAIT: begin
                if (cnt == FRAME_LAST) begin
                    state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        // Derived from next state so a LOAD->WAIT hop straight onto the last cycle still pulses.
        frame_done_n = (state_n == WAIT) && (cnt_n == FRAME_LAST);
        busy_n       = (state_n != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.ack        <= '0;
            bus.tx_start   <= 1'b0;
            bus.tx_data    <= '0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            ptr            <= IDX_W'(NREQ - 1);
`endif
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            bus.ack        <= ack_n;
            bus.tx_start   <= tx_start_n;
            bus.tx_data    <= tx_data_n;
            bus.busy       <= busy_n;
            bus.frame_done <= frame_done_n;
`ifndef ARB_FIXED_PRIO_EN
            ptr            <= ptr_n;
`endif
        end
    end

endmodule
